slave_tx_arbiter: RTL and testbench

SLAVE_TX_ARBITER -- requirements
Module: slave_tx_arbiter

---
 rtl/slave_tx_arbiter.sv | 135 +++++++++++++
 tb/tb_slave_tx_arbiter.sv | 172 +++++++++++++++++
 2 files changed

// File: rtl/slave_tx_arbiter.sv
// Round-robin arbiter that takes one word from a slave requester and sends it serially, LSB first.
// Define SLAVE_TX_PARITY_EN to append an even-parity bit after the payload.
module slave_tx_arbiter #(
  parameter int NUM_REQ = 4,
  parameter int DATA_W  = 8
) (
  input  logic                        clk,
  input  logic                        reset,
  input  logic [NUM_REQ-1:0]          req_valid,
  input  logic [NUM_REQ*DATA_W-1:0]   req_data,
  output logic [NUM_REQ-1:0]          req_ready,
  input  logic                        m_ready,
  output logic                        tx_data,
  output logic                        tx_valid,
  output logic                        tx_done,
  output logic [$clog2(NUM_REQ)-1:0]  grant_id,
  output logic                        busy,
  output logic [1:0]                  state_dbg
);

  localparam int IDW = $clog2(NUM_REQ);
  localparam int CW  = $clog2(DATA_W + 2);
`ifdef SLAVE_TX_PARITY_EN
  localparam int LAST = DATA_W + 1;
`else
  localparam int LAST = DATA_W;
`endif
  localparam logic [CW-1:0] LAST_C = CW'(LAST);
  localparam logic [CW-1:0] DATA_C = CW'(DATA_W);

  typedef enum logic [1:0] {IDLE = 2'd0, SHIFT = 2'd1, DONE = 2'd2} state_t;

  // Handshake semantics: a word moves on a rising edge where req_valid[k] and
  // req_ready[k] are both high; req_ready is offered only in IDLE with m_ready
  // high, to one requester, and never depends on the handshake having happened.

  state_t              state, state_nxt;
  logic [IDW-1:0]      rr_ptr;
  logic [IDW-1:0]      win;
  logic [IDW-1:0]      cand;
  logic                any_valid;
  logic                hs;
  logic [DATA_W-1:0]   win_word;
  logic [DATA_W-1:0]   sreg;
  logic                par;
  logic [CW-1:0]       bit_cnt;

  // First valid requester at or after rr_ptr, wrapping.
  always_comb begin
    win       = '0;
    cand      = '0;
    any_valid = 1'b0;
    for (int i = 0; i < NUM_REQ; i++) begin
      cand = IDW'((int'(rr_ptr) + i) % NUM_REQ);
      if (!any_valid && req_valid[cand]) begin
        any_valid = 1'b1;
        win       = cand;
      end
    end
  end

  always_comb begin
    req_ready = '0;
    if (reset && (state == IDLE) && m_ready && any_valid)
      req_ready[win] = 1'b1;
  end

  assign hs       = |req_ready;
  assign win_word = req_data[int'(win)*DATA_W +: DATA_W];

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) state <= IDLE;
    else        state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (hs) state_nxt = SHIFT;
      SHIFT:   if (bit_cnt == LAST_C) state_nxt = DONE;
      DONE:    state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_comb begin
    tx_done   = (state == DONE);
    busy      = (state != IDLE);
    state_dbg = state;
  end

  // bit_cnt holds the number of bits already placed on tx_data for this word.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      sreg     <= '0;
      par      <= 1'b0;
      bit_cnt  <= '0;
      tx_data  <= 1'b0;
      tx_valid <= 1'b0;
      grant_id <= '0;
      rr_ptr   <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (hs) begin
            sreg     <= win_word >> 1;
            par      <= ^win_word;
            tx_data  <= win_word[0];
            tx_valid <= 1'b1;
            bit_cnt  <= CW'(1);
            grant_id <= win;
            rr_ptr   <= IDW'((int'(win) + 1) % NUM_REQ);
          end
        end
        SHIFT: begin
          if (bit_cnt == LAST_C) begin
            tx_data  <= 1'b0;
            tx_valid <= 1'b0;
            bit_cnt  <= '0;
          end else begin
            bit_cnt <= bit_cnt + 1'b1;
            if (bit_cnt < DATA_C) begin
              tx_data <= sreg[0];
              sreg    <= sreg >> 1;
            end else begin
              tx_data <= par;
            end
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_slave_tx_arbiter.sv
// Directed bench for slave_tx_arbiter: arbitration order, serial framing, reset abort, parity.
module tb_slave_tx_arbiter;

  localparam int NUM_REQ = 4;
  localparam int DATA_W  = 8;
`ifdef SLAVE_TX_PARITY_EN
  localparam int DONE_CYC = 10;
`else
  localparam int DONE_CYC = 9;
`endif

  logic                       clk = 1'b0;
  logic                       reset;
  logic [NUM_REQ-1:0]         req_valid;
  logic [NUM_REQ*DATA_W-1:0]  req_data;
  logic [NUM_REQ-1:0]         req_ready;
  logic                       m_ready;
  logic                       tx_data;
  logic                       tx_valid;
  logic                       tx_done;
  logic [1:0]                 grant_id;
  logic                       busy;
  logic [1:0]                 state_dbg;

  int n_tests = 0;
  int n_fail  = 0;
  logic [0:0] exp_q[$];

  slave_tx_arbiter #(.NUM_REQ(NUM_REQ), .DATA_W(DATA_W)) dut (
    .clk(clk), .reset(reset), .req_valid(req_valid), .req_data(req_data),
    .req_ready(req_ready), .m_ready(m_ready), .tx_data(tx_data),
    .tx_valid(tx_valid), .tx_done(tx_done), .grant_id(grant_id),
    .busy(busy), .state_dbg(state_dbg)
  );

  // clock / reset
  always #5 clk = ~clk;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp_v);
    n_tests++;
    if (obs !== exp_v) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp_v);
    end
  endtask

  // Called in the handshake cycle (cycle 0); returns in the first IDLE cycle after DONE.
  task automatic xfer(input logic [7:0] w, input int id);
    logic [NUM_REQ*DATA_W-1:0] saved_data;
    logic                      saved_m;
    logic [3:0]                exp_rdy;
    exp_rdy = 4'b0001 << id;
    chk("hs_ready", req_ready, exp_rdy);
    chk("hs_busy", busy, 0);
    for (int i = 0; i < DATA_W; i++) exp_q.push_back(w[i]);
`ifdef SLAVE_TX_PARITY_EN
    exp_q.push_back(^w);
`endif
    saved_data = req_data;
    saved_m    = m_ready;
    step();
    chk("shift_ready", req_ready, 0);
    chk("shift_busy", busy, 1);
    for (int c = 1; c < DONE_CYC; c++) begin
      if (c == 2) begin
        m_ready  = 1'b0;
        req_data = ~saved_data;
      end
      chk("tx_valid", tx_valid, 1);
      chk("tx_data", tx_data, exp_q.pop_front());
      chk("tx_done_early", tx_done, 0);
      step();
    end
    req_data = saved_data;
    m_ready  = saved_m;
    chk("done_pulse", tx_done, 1);
    chk("done_valid", tx_valid, 0);
    chk("done_data", tx_data, 0);
    chk("done_ready", req_ready, 0);
    chk("grant_id", grant_id, id);
    step();
    chk("done_once", tx_done, 0);
    chk("idle_busy", busy, 0);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not complete");
    $fatal(1);
  end

  initial begin
    reset     = 1'b0;
    req_valid = 4'hF;
    m_ready   = 1'b1;
    req_data  = {8'h07, 8'hF0, 8'h3C, 8'hA5};
    #12;
    chk("rst_ready", req_ready, 0);
    chk("rst_valid", tx_valid, 0);
    chk("rst_data", tx_data, 0);
    chk("rst_done", tx_done, 0);
    chk("rst_busy", busy, 0);
    chk("rst_grant", grant_id, 0);
    step();
    reset     = 1'b1;
    req_valid = 4'b0001;
    #1;
    xfer(8'hA5, 0);

    // requester 2 waits for m_ready
    req_valid = 4'b0100;
    m_ready   = 1'b0;
    repeat (5) begin
      #1;
      chk("hold_ready", req_ready, 0);
      chk("hold_busy", busy, 0);
      step();
    end
    m_ready = 1'b1;
    #1;
    xfer(8'hF0, 2);

    // set rr_ptr to 2, then 1010 -> 3 then 1
    req_valid = 4'b0010;
    #1;
    xfer(8'h3C, 1);
    req_valid = 4'b1010;
    #1;
    xfer(8'h07, 3);
    xfer(8'h3C, 1);

    // reset in cycle 4 of a transfer
    req_valid = 4'b0001;
    #1;
    chk("abort_hs", req_ready, 4'b0001);
    repeat (4) step();
    chk("abort_pre_valid", tx_valid, 1);
    reset = 1'b0;
    #1;
    chk("abort_valid", tx_valid, 0);
    chk("abort_busy", busy, 0);
    chk("abort_done", tx_done, 0);
    chk("abort_ready", req_ready, 0);
    step();
    chk("abort_no_done", tx_done, 0);
    reset     = 1'b1;
    req_valid = 4'hF;
    #1;
    xfer(8'hA5, 0);
    xfer(8'h3C, 1);
    xfer(8'hF0, 2);
    xfer(8'h07, 3);
    xfer(8'hA5, 0);

    // word 0x07: parity bit 1 when enabled
    req_valid = 4'b1000;
    #1;
    xfer(8'h07, 3);
    req_valid = 4'b0000;
    #1;
    chk("final_ready", req_ready, 0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
